// File: rtl/morty_pkg.sv
// Shared definitions for the Morty memory-access stage: access-size encodings,
// exception codes, the data-bus request payload and the stage FSM states.
package morty_pkg;

    localparam int unsigned XLEN = 32;

    // mem_size encodings; 2'b11 is handled as a word access
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] EXC_NONE        = 4'd0;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    // Registered Wishbone request payload
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] dat;
        logic [3:0]      sel;
        logic            we;
    } wb_req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/morty_mem_align.sv
// Combinational byte-lane logic for the memory stage.
// Ports:
//   acc_size/acc_lo  size and addr[1:0] of the current request
//   st_wdata         raw store data (rs2)
//   acc_aligned      request is naturally aligned for its size
//   st_sel/st_data   store byte enables and lane-replicated store data
//   ld_size/ld_lo/ld_unsigned  attributes of the outstanding load
//   ld_raw           bus read data, ld_data extracted and extended result
module morty_mem_align
    import morty_pkg::*;
(
    input  logic [1:0]  acc_size,
    input  logic [1:0]  acc_lo,
    input  logic [31:0] st_wdata,
    output logic        acc_aligned,
    output logic [3:0]  st_sel,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Store lane steering and alignment check
    always_comb begin
        acc_aligned = 1'b1;
        st_sel      = 4'b1111;
        st_data     = st_wdata;
        case (acc_size)
            SIZE_BYTE: begin
                st_sel  = 4'b0001 << acc_lo;
                st_data = {4{st_wdata[7:0]}};
            end
            SIZE_HALF: begin
                acc_aligned = ~acc_lo[0];
                st_sel      = acc_lo[1] ? 4'b1100 : 4'b0011;
                st_data     = {2{st_wdata[15:0]}};
            end
            default: acc_aligned = (acc_lo == 2'b00);
        endcase
    end

    // Load extraction: bring the addressed lane to bit 0, then extend
    always_comb begin
        shifted = ld_raw >> {ld_lo, 3'b000};
        ld_data = shifted;
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default:   ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/morty_mem_unit.sv
// Memory-access stage: one Wishbone-classic data transaction per load/store,
// with lane steering, load extension, misalignment/fault reporting and a
// pipeline stall while the transaction is outstanding.
// Ports:
//   clk, rst (async, active-low)
//   flush_i, mem_valid_i, mem_re_i, mem_we_i, mem_size_i, mem_unsigned_i,
//   addr_i, wdata_i, exc_i            EX/MEM instruction
//   rdata_o, exc_o                    result to MEM/WB
//   stall_o                           hold EX/MEM and upstream
//   dwbm_*                            Wishbone master
module morty_mem_unit
    import morty_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        mem_valid_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  exc_i,
    output logic [31:0] rdata_o,
    output logic [3:0]  exc_o,
    output logic        stall_o,
    output logic [31:0] dwbm_addr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_we_o,
    output logic        dwbm_cyc_o,
    output logic        dwbm_stb_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    mem_state_e state, state_next;

    wb_req_t          bus_q;
    logic             cyc_q;
    logic [1:0]       lo_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drop_q;
    logic [31:0]      rdata_q;
    logic [3:0]       exc_q;

    logic        req;
    logic        aligned;
    logic [3:0]  sel_c;
    logic [31:0] st_data_c;
    logic [31:0] ld_data_c;
    logic        timeout_hit;
    logic        launch;
    logic        finish;
    logic        fault;

    assign req         = mem_valid_i & (mem_re_i | mem_we_i) & (exc_i == EXC_NONE) & ~flush_i;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    morty_mem_align u_align (
        .acc_size    (mem_size_i),
        .acc_lo      (addr_i[1:0]),
        .st_wdata    (wdata_i),
        .acc_aligned (aligned),
        .st_sel      (sel_c),
        .st_data     (st_data_c),
        .ld_size     (size_q),
        .ld_lo       (lo_q),
        .ld_unsigned (uns_q),
        .ld_raw      (dwbm_dat_i),
        .ld_data     (ld_data_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next state, stall and result presentation
    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        exc_o      = EXC_NONE;
        rdata_o    = '0;
        launch     = 1'b0;
        finish     = 1'b0;
        fault      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_valid_i && !flush_i && exc_i != EXC_NONE) begin
                    exc_o = exc_i;
                end else if (req && !aligned) begin
                    exc_o = mem_we_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                end else if (req) begin
                    stall_o    = 1'b1;
                    launch     = 1'b1;
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                stall_o = 1'b1;
                // err outranks a simultaneous ack
                if (dwbm_err_i || (!dwbm_ack_i && timeout_hit)) begin
                    finish = 1'b1;
                    fault  = 1'b1;
                end else if (dwbm_ack_i) begin
                    finish = 1'b1;
                end
                if (finish) state_next = ST_DONE;
            end
            ST_DONE: begin
                rdata_o    = rdata_q;
                exc_o      = exc_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request registers, watchdog, drop flag and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_q   <= '0;
            cyc_q   <= 1'b0;
            lo_q    <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            if (launch) begin
                bus_q.addr <= {addr_i[31:2], 2'b00};
                bus_q.dat  <= st_data_c;
                bus_q.sel  <= sel_c;
                bus_q.we   <= mem_we_i;
                cyc_q      <= 1'b1;
                lo_q       <= addr_i[1:0];
                size_q     <= mem_size_i;
                uns_q      <= mem_unsigned_i;
                cnt_q      <= '0;
                drop_q     <= 1'b0;
            end
            if (state == ST_BUS) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (flush_i) drop_q <= 1'b1;
            end
            if (finish) begin
                cyc_q <= 1'b0;
                // a flushed instruction completes its bus cycle but reports nothing
                if (drop_q || flush_i) begin
                    rdata_q <= '0;
                    exc_q   <= EXC_NONE;
                end else if (fault) begin
                    rdata_q <= '0;
                    exc_q   <= bus_q.we ? EXC_ST_FAULT : EXC_LD_FAULT;
                end else begin
                    rdata_q <= ld_data_c;
                    exc_q   <= EXC_NONE;
                end
            end
        end
    end

    assign dwbm_addr_o = bus_q.addr;
    assign dwbm_dat_o  = bus_q.dat;
    assign dwbm_sel_o  = bus_q.sel;
    assign dwbm_we_o   = bus_q.we;
    assign dwbm_cyc_o  = cyc_q;
    assign dwbm_stb_o  = cyc_q;

endmodule

// File: doc/morty_mem_unit.md
# morty_mem_unit

Memory-access stage of the Morty pipeline, directly downstream of the EX/MEM register. It consumes the ALU result as a data address and rs2 as store data, runs one Wishbone-classic data-bus transaction per load/store, steers byte lanes, sign/zero-extends loads, and reports misaligned and access-fault exceptions. While a transaction is outstanding it drives `stall_o`, which the pipeline control uses as `stall_exmem` for the EX/MEM register and upstream stages.

## Interface
Parameters:
- `TIMEOUT`, 255: bus cycles to wait for ack/err before an access fault is raised; 0 disables the watchdog.

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  current EX/MEM instruction is killed (trap/redirect).
- `mem_valid_i`  in  1  EX/MEM holds a valid instruction.
- `mem_re_i` / `mem_we_i`  in  1 each  load / store; both low means no access.
- `mem_size_i`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_unsigned_i`  in  1  zero-extend loads.
- `addr_i`  in  32  effective address (EX/MEM ALU output).
- `wdata_i`  in  32  store data (EX/MEM rs2).
- `exc_i`  in  4  exception code already carried by the instruction; 0 means none.
- `rdata_o`  out  32  extended load data to MEM/WB.
- `exc_o`  out  4  exception code to MEM/WB.
- `stall_o`  out  1  hold EX/MEM and all upstream stages.
- `dwbm_addr_o` out 32, `dwbm_dat_o` out 32, `dwbm_sel_o` out 4, `dwbm_we_o` out 1, `dwbm_cyc_o` out 1, `dwbm_stb_o` out 1: Wishbone master request.
- `dwbm_dat_i` in 32, `dwbm_ack_i` in 1, `dwbm_err_i` in 1: Wishbone response.

## Operation
- Access request: `req = mem_valid_i & (mem_re_i | mem_we_i) & exc_i==0 & !flush_i`.
- Alignment: halfword requires `addr[0]==0`; word requires `addr[1:0]==0`. A misaligned request issues no bus cycle and sets `exc_o` to 4 (load) or 6 (store) combinationally in IDLE, with `stall_o=0`.
- A nonzero `exc_i` passes through to `exc_o`, has priority over everything else, and issues no access.
- Store lanes:
  - byte: `sel = 1<<addr[1:0]`, data replicated ×4.
  - half: `sel` is 0011 or 1100, data replicated ×2.
  - word: `sel` is 1111.
- `dwbm_addr_o` is `addr_i` with bits [1:0] cleared.
- Load extraction: shift `dwbm_dat_i` right by `addr[1:0]*8`, then sign- or zero-extend from bit 7/15 according to size and `mem_unsigned_i`.
- FSM:
  - IDLE: an aligned `req` latches addr, sel, we, and wdata into the `dwbm_*` registers and moves to BUS. `stall_o = req & aligned`.
  - BUS: `cyc`, `stb`, and `stall_o` are high and the watchdog counter increments.
    - `ack`: latch extracted data, go to DONE.
    - `err` or counter reaching `TIMEOUT`: set fault 5 (load) or 7 (store), data 0, go to DONE.
    - `ack` and `err` together: `err` wins.
  - DONE: `cyc=stb=stall_o=0`. `rdata_o` and `exc_o` are valid for exactly this cycle, then return to IDLE. DONE never starts a new request.
- `flush_i` during BUS does not abort the bus cycle. A drop flag is set, the FSM still waits for the response, and in DONE it reports `rdata_o=0`, `exc_o=0`. `flush_i` in IDLE suppresses the request.
- Outside DONE, `rdata_o=0`. `exc_o` shows only pass-through or misaligned codes.

## Timing
- Reset (async, `rst=0`): state IDLE, all `dwbm_*` outputs 0, `rdata_o=0`, `exc_o=0`, counter 0, drop flag 0.
- Reset asserted mid-BUS drops `cyc`/`stb` immediately; no response is reported.
- Request first seen in cycle N:
  - N: `stall_o=1`.
  - N+1: `cyc`/`stb` high.
  - Ack in cycle M ≥ N+1: DONE at M+1, where `stall_o=0` and the result is valid.
- Minimum load/store latency: 2 stall cycles.
- Non-memory instructions and exception pass-through take 0 stall cycles.
- `dwbm_*` request signals are registered and stay constant from N+1 until the ack/err/timeout cycle inclusive.

## Structure
- `morty_pkg`: mem-size encodings, exception codes (4, 5, 6, 7), FSM state enum.
- One sub-module `morty_mem_align`: combinational store lane/sel generation and load extract/extend. The top level holds the FSM, request registers, watchdog, and drop flag.

## Test plan
- Word store, addr 0x1000_0004, data 0xDEADBEEF, ack after 3 cycles: `sel=1111`, `addr=0x1000_0004`; `stall_o` high 4 cycles; `exc_o=0`.
- Byte load, addr 0x…03, bus returns 0x80FF_FF7F: signed gives `rdata_o=0xFFFF_FF80`; unsigned gives `rdata_o=0x0000_0080`; `sel=1000`.
- Half load, addr 0x…01: no `cyc`; `exc_o=4`; `stall_o=0`. Word store at 0x…02: `exc_o=6`.
- Store with `err` asserted together with `ack`: `exc_o=7` in DONE. Load with no response and `TIMEOUT=8`: `exc_o=5` after 8 BUS cycles.
- `flush_i` pulsed in the second BUS cycle of a load: the bus still completes on ack; DONE reports `rdata_o=0`, `exc_o=0`.
- `rst` pulled low mid-BUS: `cyc`/`stb` fall the same cycle without a clock edge; after release, state is IDLE and a new request issues normally.
